// File: rtl/pixel_scan_pkg.sv
// rtl/pixel_scan_pkg.sv - shared types and widths for the pixel scan controller
package pixel_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LAST = 2'd2
    } scan_state_t;

    localparam int RGB_W       = 24;
    localparam int FRAME_CNT_W = 16;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

endpackage

// File: rtl/raster_counter.sv
// rtl/raster_counter.sv - raster-order (x,y) position counter with wrap at frame end
module raster_counter #(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int COORD_W = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               adv,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               at_eol,
    output logic               at_last
);

    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_RES - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_RES - 1);

    assign at_eol  = (x == X_MAX);
    assign at_last = at_eol && (y == Y_MAX);

    // Step through the frame; the last position wraps straight back to (0,0)
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            x <= '0;
            y <= '0;
        end else if (adv) begin
            if (at_eol) begin
                x <= '0;
                y <= at_last ? '0 : y + COORD_W'(1);
            end else begin
                x <= x + COORD_W'(1);
            end
        end
    end

endmodule

// File: rtl/pixel_scan_controller.sv
// rtl/pixel_scan_controller.sv - raster frame sequencer streaming generator pixels with frame markers
module pixel_scan_controller
    import pixel_scan_pkg::*;
#(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int COORD_W = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   continuous,
    input  logic                   abort,
    output logic [COORD_W-1:0]     pix_x,
    output logic [COORD_W-1:0]     pix_y,
    input  logic [7:0]             gen_r,
    input  logic [7:0]             gen_g,
    input  logic [7:0]             gen_b,
    output logic [RGB_W-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_sof,
    output logic                   out_eol,
    output logic                   out_eof,
    output logic                   busy,
    output logic                   done,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    scan_state_t            state;
    scan_state_t            state_nxt;
    pixel_t                 gen_pix;
    logic                   load;
    logic                   accept;
    logic                   cnt_clr;
    logic                   at_eol;
    logic                   at_last;
    logic [FRAME_CNT_W-1:0] frame_cnt_q;

    assign gen_pix.r = gen_r;
    assign gen_pix.g = gen_g;
    assign gen_pix.b = gen_b;

    assign busy        = (state != ST_IDLE);
    assign accept      = out_valid && out_ready;
    // The output stage refills whenever it is empty or being drained this cycle
    assign load        = (state == ST_RUN) && (!out_valid || out_ready) && !abort;
    // Counters sit at the origin while idle so a new frame always starts at (0,0)
    assign cnt_clr     = abort || (state == ST_IDLE);
    assign frame_count = frame_cnt_q;

    raster_counter #(
        .H_RES   (H_RES),
        .V_RES   (V_RES),
        .COORD_W (COORD_W)
    ) u_raster_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (cnt_clr),
        .adv     (load),
        .x       (pix_x),
        .y       (pix_y),
        .at_eol  (at_eol),
        .at_last (at_last)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: RUN until the last pixel is loaded, LAST until it is accepted
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start)           state_nxt = ST_RUN;
            ST_RUN:  if (load && at_last) state_nxt = ST_LAST;
            ST_LAST: if (accept)          state_nxt = continuous ? ST_RUN : ST_IDLE;
            default:                      state_nxt = ST_IDLE;
        endcase
        if (abort) begin
            state_nxt = ST_IDLE;
        end
    end

    // Output stage: capture on load, hold under backpressure, empty after the final accept
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end else if (abort) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= gen_pix;
            out_sof   <= (pix_x == '0) && (pix_y == '0);
            out_eol   <= at_eol;
            out_eof   <= at_last;
        end else if ((state == ST_LAST) && accept) begin
            out_valid <= 1'b0;
        end
    end

    // Frame completion: one-cycle done pulse and wrapping frame counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done        <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            done <= 1'b0;
            if (!abort && (state == ST_LAST) && accept) begin
                done        <= 1'b1;
                frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pixel_scan_controller.sv
// tb/tb_pixel_scan_controller.sv - randomized self-checking bench for pixel_scan_controller
module tb_pixel_scan_controller;

    localparam int AH  = 4;
    localparam int AV  = 2;
    localparam int ANP = AH * AV;

    logic clk = 1'b0;

    logic        a_rst_n, a_start, a_continuous, a_abort, a_out_ready;
    logic [9:0]  a_pix_x, a_pix_y;
    logic [7:0]  a_gen_r, a_gen_g, a_gen_b;
    logic [23:0] a_out_data;
    logic        a_out_valid, a_out_sof, a_out_eol, a_out_eof, a_busy, a_done;
    logic [15:0] a_frame_count;

    logic        b_rst_n, b_start, b_continuous, b_abort, b_out_ready;
    logic [9:0]  b_pix_x, b_pix_y;
    logic [7:0]  b_gen_r, b_gen_g, b_gen_b;
    logic [23:0] b_out_data;
    logic        b_out_valid, b_out_sof, b_out_eol, b_out_eof, b_busy, b_done;
    logic [15:0] b_frame_count;

    int checks = 0;
    int errors = 0;

    int m_idx       = 0;
    int m_frames    = 0;
    bit m_active    = 1'b0;
    bit m_valid     = 1'b0;
    bit m_done_next = 1'b0;
    int mode        = 0;
    int pat         = 0;
    int dcount      = 0;

    always #5 clk = ~clk;

    assign a_gen_r = a_pix_x[7:0];
    assign a_gen_g = a_pix_y[7:0];
    assign a_gen_b = a_pix_x[7:0] ^ a_pix_y[7:0];
    assign b_gen_r = b_pix_x[7:0];
    assign b_gen_g = b_pix_y[7:0];
    assign b_gen_b = b_pix_x[7:0] ^ b_pix_y[7:0];

    pixel_scan_controller #(.H_RES(AH), .V_RES(AV), .COORD_W(10)) u_a (
        .clk(clk), .rst_n(a_rst_n), .start(a_start), .continuous(a_continuous), .abort(a_abort),
        .pix_x(a_pix_x), .pix_y(a_pix_y), .gen_r(a_gen_r), .gen_g(a_gen_g), .gen_b(a_gen_b),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_sof(a_out_sof), .out_eol(a_out_eol), .out_eof(a_out_eof),
        .busy(a_busy), .done(a_done), .frame_count(a_frame_count)
    );

    pixel_scan_controller #(.H_RES(2), .V_RES(1), .COORD_W(10)) u_b (
        .clk(clk), .rst_n(b_rst_n), .start(b_start), .continuous(b_continuous), .abort(b_abort),
        .pix_x(b_pix_x), .pix_y(b_pix_y), .gen_r(b_gen_r), .gen_g(b_gen_g), .gen_b(b_gen_b),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_sof(b_out_sof), .out_eol(b_out_eol), .out_eof(b_out_eof),
        .busy(b_busy), .done(b_done), .frame_count(b_frame_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_rgb(input int x, input int y);
        return 32'(((x & 255) << 16) | ((y & 255) << 8) | ((x ^ y) & 255));
    endfunction

    task automatic a_check_reset();
        chk("rst_valid", 32'(a_out_valid), 32'(0));
        chk("rst_data", 32'(a_out_data), 32'(0));
        chk("rst_sof", 32'(a_out_sof), 32'(0));
        chk("rst_eol", 32'(a_out_eol), 32'(0));
        chk("rst_eof", 32'(a_out_eof), 32'(0));
        chk("rst_pix_x", 32'(a_pix_x), 32'(0));
        chk("rst_pix_y", 32'(a_pix_y), 32'(0));
        chk("rst_busy", 32'(a_busy), 32'(0));
        chk("rst_done", 32'(a_done), 32'(0));
        chk("rst_frame_count", 32'(a_frame_count), 32'(0));
    endtask

    // One clock of instance A: check against the model, drive ready, advance the model.
    task automatic a_cycle();
        bit acc;
        bit was_active;
        chk("busy", 32'(a_busy), 32'(m_active));
        chk("valid", 32'(a_out_valid), 32'(m_valid));
        chk("done", 32'(a_done), 32'(m_done_next));
        chk("frame_count", 32'(a_frame_count), m_frames);
        if (a_done) dcount++;
        if (m_valid) begin
            chk("data", 32'(a_out_data), ref_rgb(m_idx % AH, m_idx / AH));
            chk("sof", 32'(a_out_sof), 32'(m_idx == 0));
            chk("eol", 32'(a_out_eol), 32'((m_idx % AH) == AH - 1));
            chk("eof", 32'(a_out_eof), 32'(m_idx == ANP - 1));
        end
        if (!m_active) begin
            chk("idle_pix_x", 32'(a_pix_x), 32'(0));
            chk("idle_pix_y", 32'(a_pix_y), 32'(0));
        end
        case (mode)
            1:       a_out_ready = (pat % 3 == 0);
            2:       a_out_ready = 1'($urandom_range(1, 0));
            3:       a_out_ready = (m_idx != 2);
            default: a_out_ready = 1'b1;
        endcase
        pat++;
        acc        = m_valid && a_out_ready;
        was_active = m_active;
        if (!a_rst_n) begin
            m_valid = 0; m_active = 0; m_idx = 0; m_frames = 0; m_done_next = 0;
        end else if (a_abort) begin
            m_valid = 0; m_active = 0; m_idx = 0; m_done_next = 0;
        end else begin
            m_valid     = was_active && !(acc && m_idx == ANP - 1);
            m_done_next = 0;
            if (acc) begin
                if (m_idx == ANP - 1) begin
                    m_idx       = 0;
                    m_frames    = (m_frames + 1) % 65536;
                    m_done_next = 1;
                    m_active    = a_continuous;
                end else begin
                    m_idx++;
                end
            end
            if (!was_active && a_start) m_active = 1;
        end
        @(negedge clk);
    endtask

    task automatic a_run_to_idle(input string tag, input int limit);
        int n = 0;
        while (m_active && n < limit) begin
            a_cycle();
            n++;
        end
        chk(tag, 32'(m_active), 32'(0));
    endtask

    task automatic a_frame(input string tag, input int md);
        mode = md;
        a_start = 1'b1;
        a_cycle();
        a_start = 1'b0;
        a_run_to_idle(tag, 400);
        a_cycle();
    endtask

    initial begin
        int n;
        int f0;
        int d0;
        a_rst_n = 1'b0; a_start = 1'b0; a_continuous = 1'b0; a_abort = 1'b0; a_out_ready = 1'b1;
        b_rst_n = 1'b0; b_start = 1'b0; b_continuous = 1'b0; b_abort = 1'b0; b_out_ready = 1'b1;
        @(negedge clk);
        a_cycle();
        a_cycle();
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        a_check_reset();

        // single frame, ready always high: latency and length
        mode = 0; dcount = 0;
        a_start = 1'b1;
        a_cycle();
        a_start = 1'b0;
        n = 1;
        while (m_active && n < 50) begin
            a_cycle();
            n++;
        end
        chk("t1_cycles", 32'(n), 32'(ANP + 2));
        a_cycle();
        chk("t1_done_pulses", 32'(dcount), 32'(1));

        // backpressure: 1,0,0 pattern then random ready
        a_frame("t2_pattern_timeout", 1);
        a_frame("t2_random_timeout", 2);

        // continuous for three frames
        mode = 0; dcount = 0; f0 = m_frames;
        a_continuous = 1'b1;
        a_start = 1'b1;
        a_cycle();
        a_start = 1'b0;
        n = 0;
        while (m_active && n < 200) begin
            a_continuous = ((m_frames - f0 + 65536) % 65536) < 2;
            a_cycle();
            n++;
        end
        a_continuous = 1'b0;
        chk("t3_timeout", 32'(m_active), 32'(0));
        a_cycle();
        chk("t3_frames", 32'(a_frame_count), 32'((f0 + 3) % 65536));
        chk("t3_done_pulses", 32'(dcount), 32'(3));

        // abort while pixel (2,0) is held under backpressure
        mode = 3;
        a_start = 1'b1;
        a_cycle();
        a_start = 1'b0;
        n = 0;
        while (!(m_valid && m_idx == 2) && n < 20) begin
            a_cycle();
            n++;
        end
        a_cycle();
        a_cycle();
        chk("t4_held_x", 32'(a_out_data), ref_rgb(2, 0));
        f0 = m_frames; d0 = dcount;
        a_abort = 1'b1;
        a_cycle();
        a_abort = 1'b0;
        a_cycle();
        a_cycle();
        chk("t4_no_done", 32'(dcount), 32'(d0));
        chk("t4_count_kept", 32'(a_frame_count), 32'(f0));
        a_frame("t4_restart_timeout", 0);

        // start while busy, then reset mid-frame
        mode = 2;
        a_start = 1'b1;
        a_cycle();
        repeat (6) a_cycle();
        a_start = 1'b0;
        a_rst_n = 1'b0;
        a_cycle();
        a_rst_n = 1'b1;
        a_check_reset();
        a_frame("t5_after_reset_timeout", 0);

        // randomized mix of start, abort, continuous, reset and backpressure
        mode = 2;
        for (int i = 0; i < 900; i++) begin
            a_start      = ($urandom_range(5, 0) == 0);
            a_abort      = ($urandom_range(59, 0) == 0);
            a_continuous = 1'($urandom_range(1, 0));
            a_rst_n      = !($urandom_range(299, 0) == 0);
            a_cycle();
        end
        a_start = 1'b0; a_abort = 1'b0; a_continuous = 1'b0; a_rst_n = 1'b1;
        a_run_to_idle("rand_drain_timeout", 400);

        // V_RES=1, H_RES=2
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        chk("b_lat_valid", 32'(b_out_valid), 32'(0));
        chk("b_lat_busy", 32'(b_busy), 32'(1));
        @(negedge clk);
        chk("b_p0_valid", 32'(b_out_valid), 32'(1));
        chk("b_p0_data", 32'(b_out_data), 32'h000000);
        chk("b_p0_sof", 32'(b_out_sof), 32'(1));
        chk("b_p0_eol", 32'(b_out_eol), 32'(0));
        chk("b_p0_eof", 32'(b_out_eof), 32'(0));
        @(negedge clk);
        chk("b_p1_valid", 32'(b_out_valid), 32'(1));
        chk("b_p1_data", 32'(b_out_data), 32'h010001);
        chk("b_p1_sof", 32'(b_out_sof), 32'(0));
        chk("b_p1_eol", 32'(b_out_eol), 32'(1));
        chk("b_p1_eof", 32'(b_out_eof), 32'(1));
        @(negedge clk);
        chk("b_end_valid", 32'(b_out_valid), 32'(0));
        chk("b_end_done", 32'(b_done), 32'(1));
        chk("b_end_count", 32'(b_frame_count), 32'(1));
        chk("b_end_busy", 32'(b_busy), 32'(0));
        @(negedge clk);
        chk("b_done_once", 32'(b_done), 32'(0));
        force u_b.frame_cnt_q = 16'hFFFF;
        @(negedge clk);
        release u_b.frame_cnt_q;
        chk("b_preload", 32'(b_frame_count), 32'hFFFF);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("b_wrap_done", 32'(b_done), 32'(1));
        chk("b_wrap_count", 32'(b_frame_count), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

endmodule

// File: doc/pixel_scan_controller.md
Name: pixel_scan_controller

Overview:
Frame sequencer for the per-pixel colour datapath. It walks (x,y) across an H_RES x V_RES frame in raster order and drives the coordinates into the combinational colour generator. It captures each returned RGB triple into a registered output stage and streams pixels out over a valid/ready interface, with start-of-frame, end-of-line and end-of-frame markers. It sits between the simulation top and the frame-buffer/image-dump sink, and supports single-shot or continuous frames, backpressure and abort.

Parameters:
H_RES, 640, pixels per line (2..1024)
V_RES, 480, lines per frame (1..1024)
COORD_W, 10, coordinate width; must satisfy 2^COORD_W >= max(H_RES, V_RES)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  begin a frame; honoured only in IDLE
continuous  in  1  sampled at frame end; 1 = start the next frame automatically
abort  in  1  synchronous abort to IDLE
pix_x  out  COORD_W  x coordinate to colour generator (current scan position)
pix_y  out  COORD_W  y coordinate to colour generator
gen_r  in  8  red from colour generator (combinational on pix_x/pix_y)
gen_g  in  8  green
gen_b  in  8  blue
out_data  out  24  {r,g,b} of the presented pixel
out_valid  out  1  pixel present
out_ready  in  1  sink accepts when out_valid && out_ready
out_sof  out  1  presented pixel is (0,0)
out_eol  out  1  presented pixel has x == H_RES-1
out_eof  out  1  presented pixel is (H_RES-1, V_RES-1)
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when the last pixel of a frame is accepted
frame_count  out  16  completed frames, wraps at 0xFFFF -> 0

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE, pix_x=pix_y=0, out_valid=0, out_data=0, sof/eol/eof=0, done=0, frame_count=0. Reset dominates abort and start.
- States:
  - IDLE: start=1 -> RUN, with counters already 0.
  - RUN: load = !out_valid || out_ready.
    - On load: out_data<={gen_r,gen_g,gen_b}; out_valid<=1; flags computed from the current pix_x/pix_y.
    - Counter advance on load: x+1; at H_RES-1 x wraps to 0 and y+1.
    - Loading the last pixel -> LAST; the counters hold at 0,0 (wrap).
    - No load -> all outputs hold stable (AXI-style: data/flags must not change while valid && !ready).
  - LAST: no further loads. On out_valid && out_ready: out_valid<=0, done<=1 next cycle, frame_count+1.
    - If continuous=1 in that cycle -> RUN (one bubble cycle between frames); else -> IDLE.
- Latency: start high at edge N -> RUN after N; pixel (0,0) valid after edge N+1. With out_ready tied 1, throughput is one pixel per clock; a frame takes H_RES*V_RES+1 cycles from start to the final accept.
- start while busy: ignored. start and abort in the same cycle: abort wins.
- abort=1 (any state): next state IDLE, out_valid=0, counters=0, flags=0. No done pulse, frame_count unchanged. A pixel held under backpressure is dropped.
- done is asserted for exactly one cycle. busy is combinational from state.
- V_RES=1: sof and eol/eof may coincide on the same pixel; all flags are evaluated independently.

Decomposition:
- pixel_scan_pkg:
  - state enum {IDLE, RUN, LAST} (2 bits)
  - RGB_W=24
  - typedef struct pixel_t {r,g,b}
  - FRAME_CNT_W=16
- Sub-module raster_counter (params H_RES, V_RES, COORD_W):
  - inputs: clk, rst_n, clr, adv
  - outputs: x, y, at_eol, at_last
  - clr is used for both abort and frame restart.

Test Plan:
- H_RES=4, V_RES=2, reference colour generator, out_ready=1, start pulse -> 8 pixels on consecutive cycles beginning 2 edges after start. Pixel (3,1) gives out_data=0x030102 with eol=1, eof=1. Pixel (0,0) gives 0x000000 with sof=1. done pulses once; frame_count=1; busy falls.
- Same config, out_ready toggling 1,0,0,1,... -> no pixel lost or duplicated. out_data/flags stay stable while valid && !ready. Sequence order is (0,0)..(3,1).
- continuous=1 for 3 frames -> frame_count=3, exactly one bubble cycle between each eof accept and the next sof, and 3 done pulses.
- abort asserted while pixel (2,0) is held with out_ready=0 -> next cycle out_valid=0, busy=0, no done, frame_count unchanged. A following start restarts at (0,0) with sof=1.
- rst_n=0 mid-frame, plus start asserted during busy -> reset clears everything to reset values. Start during busy has no effect on sequence or count.
- V_RES=1, H_RES=2 -> pixel (0,0) has sof=1, eol=0. Pixel (1,0) has eol=1, eof=1. frame_count wraps from 0xFFFF to 0 (preload via force).
